// File: rtl/psum_accum_buf_pkg.sv
// Shared constants, FSM encoding and int8 requantization for the psum accumulation buffer.
package psum_accum_buf_pkg;

  localparam int unsigned NUM_COLS   = 32;
  localparam int unsigned PSUM_BW    = 32;
  localparam int unsigned ADDR_PSUM  = 12;
  localparam int unsigned BANK_AW    = 11;
  localparam int unsigned BANK_DEPTH = 1 << BANK_AW;
  localparam int unsigned INPUT_BW   = 8;

  localparam logic signed [PSUM_BW-1:0] QMax = PSUM_BW'((1 << (INPUT_BW - 1)) - 1);
  localparam logic signed [PSUM_BW-1:0] QMin = ~QMax;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StAccumFlush,
    StDrain
  } state_e;

  // Arithmetic shift, optional ReLU, then saturate into the signed output range.
  function automatic logic [INPUT_BW-1:0] requantize(input logic signed [PSUM_BW-1:0] sum,
                                                     input logic [4:0]               shift,
                                                     input logic                     relu_en);
    logic signed [PSUM_BW-1:0] v;
    v = sum >>> shift;
    if (relu_en && v < 0) v = '0;
    if (v > QMax) v = QMax;
    else if (v < QMin) v = QMin;
    return v[INPUT_BW-1:0];
  endfunction

endpackage

// File: rtl/psum_bank_lane.sv
// One psum bank: sync-read memory with a two-stage read-modify-write accumulate path.
module psum_bank_lane
  import psum_accum_buf_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 acc_en_i,
  input  logic                 valid_i,
  input  logic [PSUM_BW-1:0]   data_i,
  input  logic [ADDR_PSUM-1:0] addr_i,
  input  logic                 clr_we_i,
  input  logic                 rd_en_i,
  input  logic [BANK_AW-1:0]   row_i,
  output logic [PSUM_BW-1:0]   rdata_o,
  output logic                 addr_err_o
);

  logic [PSUM_BW-1:0] mem [BANK_DEPTH];

  logic               in_range;
  logic               s0_go;
  logic [BANK_AW-1:0] rd_addr;
  logic [PSUM_BW-1:0] sum;
  logic [PSUM_BW-1:0] rdata_q;

  logic               s1_valid_q;
  logic [BANK_AW-1:0] s1_addr_q;
  logic [PSUM_BW-1:0] s1_data_q;
  logic               wb_valid_q;
  logic [BANK_AW-1:0] wb_addr_q;
  logic [PSUM_BW-1:0] wb_data_q;

  assign in_range   = (addr_i[ADDR_PSUM-1:BANK_AW] == '0);
  assign s0_go      = acc_en_i & valid_i & in_range;
  assign addr_err_o = acc_en_i & valid_i & ~in_range;
  assign rd_addr    = s0_go ? addr_i[BANK_AW-1:0] : row_i;
  assign rdata_o    = rdata_q;

  // The read issued alongside last cycle's write saw the stale word; forward the written sum.
  assign sum = ((wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : rdata_q) + s1_data_q;

  always_ff @(posedge clk_i) begin
    if (s0_go || rd_en_i) rdata_q <= mem[rd_addr];
    if (!rst_i) begin
      if (clr_we_i) mem[row_i] <= '0;
      else if (s1_valid_q) mem[s1_addr_q] <= sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      s1_valid_q <= s0_go;
      s1_addr_q  <= addr_i[BANK_AW-1:0];
      s1_data_q  <= data_i;
      wb_valid_q <= s1_valid_q;
      wb_addr_q  <= s1_addr_q;
      wb_data_q  <= sum;
    end
  end

endmodule

// File: rtl/psum_accum_buf.sv
// Banked psum accumulator: clear, per-lane accumulate, and requantized row drain over valid/ready.
module psum_accum_buf
  import psum_accum_buf_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_start,
  input  logic                          accum_start,
  input  logic                          accum_done,
  input  logic [NUM_COLS-1:0]           psum_valid,
  input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
  input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
  input  logic                          drain_start,
  input  logic [BANK_AW:0]              drain_rows,
  input  logic [4:0]                    shift,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INPUT_BW*NUM_COLS-1:0]  out_data,
  output logic [BANK_AW-1:0]            out_row,
  output logic                          busy,
  output logic                          done,
  output logic                          addr_err
);

  localparam int unsigned OutW = INPUT_BW * NUM_COLS;

  state_e              state_q, state_d;
  logic [BANK_AW:0]    row_q, row_d;
  logic [BANK_AW-1:0]  last_row_q, last_row_d;
  logic [4:0]          shift_q, shift_d;
  logic                relu_q, relu_d;
  logic                flush_q, flush_d;
  logic                pend_q, pend_d;
  logic [BANK_AW-1:0]  pend_row_q, pend_row_d;
  logic                skid_valid_q, skid_valid_d;
  logic [OutW-1:0]     skid_data_q, skid_data_d;
  logic [BANK_AW-1:0]  skid_row_q, skid_row_d;
  logic                out_valid_q, out_valid_d;
  logic [OutW-1:0]     out_data_q, out_data_d;
  logic [BANK_AW-1:0]  out_row_q, out_row_d;
  logic                done_q, done_d;
  logic                addr_err_q, addr_err_d;

  logic                acc_en;
  logic                clr_we;
  logic                fire;
  logic                issue;
  logic [1:0]          occ;
  logic [PSUM_BW-1:0]  lane_rdata [NUM_COLS];
  logic [NUM_COLS-1:0] lane_err;
  logic [OutW-1:0]     quant;

  assign acc_en = (state_q == StAccum);
  assign clr_we = (state_q == StClear);
  assign fire   = out_valid_q & out_ready;
  assign occ    = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
  // A new read may issue only if the output register plus skid slot can still absorb it.
  assign issue  = (state_q == StDrain) && (row_q <= {1'b0, last_row_q}) &&
                  ((occ - {1'b0, fire}) <= 2'd1);

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_lane
    psum_bank_lane u_lane (
      .clk_i      (clk),
      .rst_i      (reset),
      .acc_en_i   (acc_en),
      .valid_i    (psum_valid[g]),
      .data_i     (psum_rows[g*PSUM_BW +: PSUM_BW]),
      .addr_i     (psum_addrs[g*ADDR_PSUM +: ADDR_PSUM]),
      .clr_we_i   (clr_we),
      .rd_en_i    (issue),
      .row_i      (row_q[BANK_AW-1:0]),
      .rdata_o    (lane_rdata[g]),
      .addr_err_o (lane_err[g])
    );
  end

  always_comb begin
    quant = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      quant[i*INPUT_BW +: INPUT_BW] = requantize(lane_rdata[i], shift_q, relu_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    last_row_d   = last_row_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    flush_d      = flush_q;
    done_d       = 1'b0;
    addr_err_d   = addr_err_q | (|lane_err);
    pend_d       = issue;
    pend_row_d   = row_q[BANK_AW-1:0];
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_row_d   = skid_row_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_row_d    = out_row_q;

    if (fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_row_d    = skid_row_q;
        skid_valid_d = pend_q;
        skid_data_d  = quant;
        skid_row_d   = pend_row_q;
      end else begin
        out_valid_d = pend_q;
        if (pend_q) begin
          out_data_d = quant;
          out_row_d  = pend_row_q;
        end
      end
    end else if (pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = quant;
      skid_row_d   = pend_row_q;
    end

    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d    = StClear;
          row_d      = '0;
          addr_err_d = 1'b0;
        end else if (accum_start) begin
          state_d = StAccum;
        end else if (drain_start) begin
          state_d    = StDrain;
          row_d      = '0;
          last_row_d = (drain_rows == '0) ? '0 : BANK_AW'(drain_rows - 1'b1);
          shift_d    = shift;
          relu_d     = relu_en;
        end
      end
      StClear: begin
        row_d = row_q + 1'b1;
        if (row_q[BANK_AW-1:0] == '1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StAccum: begin
        if (accum_done) begin
          state_d = StAccumFlush;
          flush_d = 1'b0;
        end
      end
      StAccumFlush: begin
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StDrain: begin
        if (issue) row_d = row_q + 1'b1;
        if (fire && (out_row_q == last_row_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      last_row_q   <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      flush_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_row_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_row_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      done_q       <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      last_row_q   <= last_row_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      flush_q      <= flush_d;
      pend_q       <= pend_d;
      pend_row_q   <= pend_row_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_row_q   <= skid_row_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      done_q       <= done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Scoreboarded random/directed bench for psum_accum_buf against a plain-array bank model.
module tb_psum_accum_buf;
  import psum_accum_buf_pkg::*;

  localparam int NC = NUM_COLS;
  localparam int OW = INPUT_BW * NUM_COLS;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     clear_start = 1'b0, accum_start = 1'b0, accum_done = 1'b0;
  logic [NC-1:0]            psum_valid = '0;
  logic [PSUM_BW*NC-1:0]    psum_rows = '0;
  logic [ADDR_PSUM*NC-1:0]  psum_addrs = '0;
  logic                     drain_start = 1'b0;
  logic [BANK_AW:0]         drain_rows = '0;
  logic [4:0]               shift = '0;
  logic                     relu_en = 1'b0;
  logic                     out_valid, out_ready = 1'b1;
  logic [OW-1:0]            out_data;
  logic [BANK_AW-1:0]       out_row;
  logic                     busy, done, addr_err;

  psum_accum_buf dut (
    .clk(clk), .reset(reset), .clear_start(clear_start), .accum_start(accum_start),
    .accum_done(accum_done), .psum_valid(psum_valid), .psum_rows(psum_rows),
    .psum_addrs(psum_addrs), .drain_start(drain_start), .drain_rows(drain_rows),
    .shift(shift), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done), .addr_err(addr_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int            row;
    logic [OW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    mdl [NC][BANK_DEPTH];
  int    n_tot = 0, n_pass = 0;
  int    ready_mode = 0;
  bit    chk_data = 1'b1;

  function automatic void chk(bit ok, string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  function automatic logic [7:0] model_quant(int s, int sh, bit relu);
    int v;
    v = s >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(seen, name, OW'(seen), OW'(1));
  endtask

  task automatic set_lane(input int l, input bit v, input int a, input int d, input bit upd);
    psum_valid[l] = v;
    psum_rows[l*PSUM_BW +: PSUM_BW] = d;
    psum_addrs[l*ADDR_PSUM +: ADDR_PSUM] = ADDR_PSUM'(a);
    if (upd && v && a < int'(BANK_DEPTH)) mdl[l][a] += d;
  endtask

  task automatic do_clear(input bit count_cycles);
    int cnt;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      tick();
    end
    if (count_cycles) begin
      chk(cnt == int'(BANK_DEPTH), "clear_cycles", OW'(cnt), OW'(BANK_DEPTH));
      chk(done == 1'b1, "clear_done", OW'(done), OW'(1));
      tick();
      chk(done == 1'b0, "clear_done_pulse", OW'(done), OW'(0));
    end else begin
      wait_done(10, "clear_done");
    end
    for (int l = 0; l < NC; l++)
      for (int r = 0; r < int'(BANK_DEPTH); r++) mdl[l][r] = 0;
  endtask

  task automatic start_drain(input int rows, input int sh, input bit relu, input int mode);
    beat_t b;
    int    n;
    n = (rows == 0) ? 1 : rows;
    for (int r = 0; r < n; r++) begin
      b.row = r;
      for (int l = 0; l < NC; l++) b.data[l*8 +: 8] = model_quant(mdl[l][r], sh, relu);
      exp_q.push_back(b);
    end
    shift = 5'(sh);
    relu_en = relu;
    drain_rows = (BANK_AW + 1)'(rows);
    ready_mode = mode;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic run_drain(input int rows, input int sh, input bit relu, input int mode);
    start_drain(rows, sh, relu, mode);
    wait_done(rows * 6 + 40, "drain_done");
    tick();
    tick();
    chk(exp_q.size() == 0, "drain_beats_left", OW'(exp_q.size()), OW'(0));
  endtask

  task automatic end_accum();
    psum_valid = '0;
    accum_done = 1'b0;
    wait_done(10, "accum_done");
  endtask

  // Downstream ready: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = (k % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    bit            stalled;
    logic [OW-1:0] st_data;
    logic [BANK_AW-1:0] st_row;
    beat_t         b;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk(out_valid && out_data == st_data && out_row == st_row, "stall_hold",
              out_data, st_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", OW'(out_row), OW'(0));
          end else begin
            b = exp_q.pop_front();
            chk(int'(out_row) == b.row, "beat_row", OW'(out_row), OW'(b.row));
            if (chk_data) chk(out_data == b.data, "beat_data", out_data, b.data);
          end
        end
        stalled = out_valid && !out_ready;
        st_data = out_data;
        st_row  = out_row;
      end
    end
  end

  initial begin
    bit found;
    repeat (3) tick();
    chk(out_valid == 0, "rst_out_valid", OW'(out_valid), OW'(0));
    chk(busy == 0, "rst_busy", OW'(busy), OW'(0));
    chk(done == 0, "rst_done", OW'(done), OW'(0));
    chk(addr_err == 0, "rst_addr_err", OW'(addr_err), OW'(0));
    chk(out_row == 0, "rst_out_row", OW'(out_row), OW'(0));
    chk(out_data == 0, "rst_out_data", out_data, OW'(0));
    reset = 1'b0;
    tick();

    do_clear(1'b1);
    run_drain(int'(BANK_DEPTH), 0, 1'b0, 0);

    // Beat in IDLE must be ignored; then four back-to-back hits on one address.
    set_lane(3, 1'b1, 5, 100, 1'b0);
    tick();
    psum_valid = '0;
    accum_start = 1'b1;
    tick();
    accum_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(3, 1'b1, 5, 100, 1'b1);
      accum_done = (i == 3);
      tick();
    end
    end_accum();
    run_drain(8, 0, 1'b0, 0);
    run_drain(8, 2, 1'b0, 0);

    accum_start = 1'b1;
    tick();
    accum_start = 1'b0;
    for (int l = 0; l < NC; l++) set_lane(l, 1'b1, 0, -1000, 1'b1);
    accum_done = 1'b1;
    tick();
    end_accum();
    run_drain(8, 3, 1'b0, 0);
    run_drain(8, 3, 1'b1, 0);
    run_drain(4, 3, 1'b0, 1);

    accum_start = 1'b1;
    tick();
    accum_start = 1'b0;
    set_lane(0, 1'b1, 'h800, 55, 1'b1);
    accum_done = 1'b1;
    tick();
    end_accum();
    chk(addr_err == 1, "addr_err_set", OW'(addr_err), OW'(1));
    run_drain(8, 0, 1'b0, 2);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk(addr_err == 0, "addr_err_clr", OW'(addr_err), OW'(0));
    wait_done(BANK_DEPTH + 10, "clear2_done");
    for (int l = 0; l < NC; l++)
      for (int r = 0; r < int'(BANK_DEPTH); r++) mdl[l][r] = 0;

    for (int rnd = 0; rnd < 3; rnd++) begin
      accum_start = 1'b1;
      tick();
      accum_start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        for (int l = 0; l < NC; l++)
          set_lane(l, 1'($urandom_range(0, 1)), $urandom_range(0, 7), int'($urandom), 1'b1);
        accum_done = (c == 39);
        tick();
      end
      end_accum();
      run_drain(8, $urandom_range(0, 24), 1'($urandom_range(0, 1)), 2);
    end
    run_drain(0, 0, 1'b0, 0);

    start_drain(8, 0, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_row == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(found, "reach_row2", OW'(found), OW'(1));
    reset = 1'b1;
    tick();
    chk(out_valid == 0, "mid_rst_valid", OW'(out_valid), OW'(0));
    chk(busy == 0, "mid_rst_busy", OW'(busy), OW'(0));
    chk(done == 0, "mid_rst_done", OW'(done), OW'(0));
    exp_q.delete();
    reset = 1'b0;
    tick();
    chk_data = 1'b0;
    run_drain(4, 0, 1'b0, 0);
    chk_data = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
